// File: rtl/led_blink_decoder.sv
// led_blink_decoder
// Receive-side decoder for a single-bit LED blink line. The line is
// synchronised into the clock domain, split into high pulses and low gaps by
// a saturating run-length timer, and every burst of valid pulses followed by a
// long enough low gap is reported as a one-cycle o_valid strobe with the number
// of pulses seen (o_count) and a sticky overflow flag (o_overflow).
//
// Pulses shorter than MIN_PULSE_CYCLES are glitches: they never add to the
// count. A glitch inside a burst restarts the gap timer. A glitch seen while
// no valid pulse has been counted yet drops the decoder back to idle.

module led_blink_decoder #(
  parameter int unsigned MIN_PULSE_CYCLES = 1 << 10,
  parameter int unsigned GAP_CYCLES       = 1 << 24,
  parameter int unsigned COUNT_WIDTH      = 4,
  parameter int unsigned TIMER_WIDTH      = 25
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_line,
  output logic                   o_valid,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_overflow,
  output logic                   o_busy
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for the first high sample
  localparam logic [1:0] ST_HIGH = 2'd1;  // timing a high pulse
  localparam logic [1:0] ST_LOW  = 2'd2;  // timing the low gap inside a burst

  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = '1;
  localparam logic [TIMER_WIDTH-1:0] MIN_PULSE  = TIMER_WIDTH'(MIN_PULSE_CYCLES);
  // The first low sample loads the timer with 1, so the GAP_CYCLES-th low
  // sample is the one that finds the timer at GAP_CYCLES-1.
  localparam logic [TIMER_WIDTH-1:0] GAP_LAST   = TIMER_WIDTH'(GAP_CYCLES - 1);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic                   sync1_q;     // first synchroniser stage (may go metastable)
  logic                   s_line_q;    // synchronised line, the only input used below

  logic [1:0]             state_q,     state_d;
  logic [TIMER_WIDTH-1:0] timer_q,     timer_d;
  logic [COUNT_WIDTH-1:0] cnt_q,       cnt_d;
  logic                   ovf_q,       ovf_d;

  logic                   valid_q,     valid_d;
  logic [COUNT_WIDTH-1:0] count_q,     count_d;
  logic                   ovf_out_q,   ovf_out_d;

  logic [TIMER_WIDTH-1:0] timer_inc;

  // Two-flop synchroniser bringing the asynchronous blink line into i_clk.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the two stages.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= 1'b0;
      s_line_q <= 1'b0;
    end else begin
      sync1_q  <= i_line;
      s_line_q <= sync1_q;
    end
  end

  // Saturating increment of the run-length timer: a line stuck at one level
  // must never wrap the timer back into a range that looks like a short run.
  always_comb begin
    timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_ONE;
  end

  // Next-state logic: classify each synchronised sample against the current
  // run and decide pulse / glitch / gap-end.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    count_d   = count_q;
    ovf_out_d = ovf_out_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        if (s_line_q) begin
          state_d = ST_HIGH;
          timer_d = TIMER_ONE;
        end
      end

      ST_HIGH: begin
        if (s_line_q) begin
          timer_d = timer_inc;
        end else if (timer_q >= MIN_PULSE) begin
          // Falling edge after a long enough pulse: count it, or flag
          // overflow once the counter is already at its maximum.
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
          state_d = ST_LOW;
          timer_d = TIMER_ONE;
        end else begin
          // Glitch: nothing is counted. Inside a burst it restarts the gap;
          // before any valid pulse there is no burst to keep alive.
          timer_d = TIMER_ONE;
          state_d = (cnt_q != '0) ? ST_LOW : ST_IDLE;
        end
      end

      ST_LOW: begin
        if (s_line_q) begin
          state_d = ST_HIGH;
          timer_d = TIMER_ONE;
        end else if (timer_q == GAP_LAST) begin
          // Gap long enough: publish the burst and return to idle.
          valid_d   = 1'b1;
          count_d   = cnt_q;
          ovf_out_d = ovf_q;
          state_d   = ST_IDLE;
          timer_d   = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // Decoder state and result registers; reset discards any partial burst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  // Outputs come straight from flops; o_busy depends on the state register
  // only, so there is no combinational path from i_line.
  always_comb begin
    o_valid    = valid_q;
    o_count    = count_q;
    o_overflow = ovf_out_q;
    o_busy     = (state_q != ST_IDLE);
  end

endmodule

// File: doc/led_blink_decoder.md
Name: led_blink_decoder

Overview:
- Receive-side counterpart of the LED blink state machine: samples a single-bit blink line and recovers the number of blinks in each burst.
- A burst is a run of high pulses, terminated by a low gap of at least GAP_CYCLES.
- Used on-board to loop an LED pattern back from an input pin for self-check, and in simulation as the checker for blink generators.
- Reports each burst as a one-cycle o_valid strobe with o_count and o_overflow.

Parameters:
- MIN_PULSE_CYCLES, 1<<10: minimum consecutive synced-high cycles for a pulse to count. Shorter pulses are glitches.
- GAP_CYCLES, 1<<24: consecutive synced-low cycles that end a burst.
- COUNT_WIDTH, 4: width of the blink counter and of o_count.
- TIMER_WIDTH, 25: width of the pulse/gap timer. Must hold max(MIN_PULSE_CYCLES, GAP_CYCLES).

Ports:
- i_clk  in  1  system clock (16MHz on board)
- i_rst_n  in  1  asynchronous active-low reset
- i_line  in  1  blink line, asynchronous to i_clk
- o_valid  out  1  one-cycle strobe: burst complete
- o_count  out  COUNT_WIDTH  blinks in last burst; held until next o_valid
- o_overflow  out  1  last burst exceeded 2^COUNT_WIDTH-1 blinks; held with o_count
- o_busy  out  1  high while a burst is in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync release): all flops clear; state IDLE; o_valid=0, o_count=0, o_overflow=0, o_busy=0.
- Synchronizer: two flops i_line -> s_line. All decisions use s_line only, giving 2 cycles of input latency.
- Internal registers: state, timer (TIMER_WIDTH, saturating), cnt (COUNT_WIDTH), ovf.
- IDLE:
  - timer=0, cnt=0, ovf=0.
  - s_line=1 -> HIGH, timer=1.
- HIGH:
  - s_line=1 -> timer++ (saturates at all-ones, never wraps).
  - s_line=0 and timer>=MIN_PULSE_CYCLES -> valid pulse. If cnt==max, set ovf and hold cnt; else cnt++. Then go to LOW, timer=1.
  - s_line=0 and timer<MIN_PULSE_CYCLES -> glitch, cnt unchanged, timer=1. Go to LOW if cnt!=0, else IDLE.
- LOW:
  - s_line=1 -> HIGH, timer=1.
  - s_line=0 and timer==GAP_CYCLES-1 -> burst end, on the same edge:
    - o_valid=1, o_count=cnt, o_overflow=ovf;
    - state IDLE, cnt=0, ovf=0.
  - otherwise timer++.
- Gap timing: o_valid rises on the edge where s_line has been low for exactly GAP_CYCLES consecutive samples, counting the falling-edge sample as the first.
- o_valid is high for exactly one cycle; it is never asserted from IDLE or HIGH.
- A line stuck high never produces o_valid; the timer saturates and o_busy stays 1.
- A pulse exactly MIN_PULSE_CYCLES long counts. A gap of GAP_CYCLES-1 does not end the burst.
- A glitch restarts the gap timer.
- A reset mid-burst discards the partial burst with no o_valid. The next burst decodes normally.
- o_busy = (state != IDLE), registered-state derived, no combinational path from i_line.

Test Plan (MIN_PULSE_CYCLES=4, GAP_CYCLES=16, COUNT_WIDTH=3, TIMER_WIDTH=8):
1. Three pulses of 8 high / 8 low, then line low -> one o_valid, o_count=3, o_overflow=0, rising 16 synced-low cycles after the last falling edge; o_busy low the next cycle.
2. Real pulse, 2-cycle glitch, real pulse (8-cycle widths, 8-cycle spacing), then low -> o_count=2.
3. Pulse widths of 4 then 3 cycles, separated by 15-cycle lows, then 16 low -> single o_valid with o_count=1. The 15-cycle lows do not end the burst.
4. Nine 8-cycle pulses, then low -> o_count=7, o_overflow=1. A following 1-pulse burst -> o_count=1, o_overflow=0.
5. Two pulses, then assert i_rst_n=0 mid-gap -> all outputs 0 immediately, no o_valid. After release, a 1-pulse burst -> o_count=1.
6. Line held high 300 cycles (timer saturates), then low -> no o_valid while high, o_busy=1; after 16 low cycles o_valid with o_count=1.
